// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous clock in units of clk cycles.
// Lock is kept while rising edges keep arriving within TIMEOUT clk cycles of each other.
module clk_period_meter #(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_clk,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TO_LIM = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic             take_meas, to_hit;
  logic [WIDTH-1:0] per_cnt, hi_cnt, hi_latched;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // A rise beats an expiring per_cnt in the same cycle, so period == TIMEOUT is a valid measurement.
  always_comb begin
    state_d   = state;
    take_meas = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_d = ARM;
      end
      ARM, LOCKED: begin
        if (rise) begin
          state_d   = LOCKED;
          take_meas = 1'b1;
        end else if (per_cnt == TO_LIM) begin
          state_d = IDLE;
          to_hit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      hi_latched <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= in_clk;
      s2         <= s1;
      s3         <= s2;
      state      <= state_d;
      meas_valid <= take_meas;
      timeout    <= to_hit;
      locked     <= (state_d == LOCKED);

      if (rise) begin
        per_cnt <= ONE;
        hi_cnt  <= ONE;
        if (state != IDLE) begin
          period    <= per_cnt;
          high_time <= hi_latched;
        end
      end else if (state != IDLE) begin
        // per_cnt parks at TIMEOUT on expiry and is frozen in IDLE, so it never wraps.
        if (!to_hit) per_cnt <= per_cnt + ONE;
        if (fall) begin
          hi_latched <= hi_cnt;
        end else if (s2) begin
          hi_cnt <= hi_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: event-time reference model plus directed phases.
module tb_clk_period_meter;

  localparam int W  = 32;
  localparam int TO = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_clk = 1'b0;
  logic [W-1:0] period, high_time;
  logic         meas_valid, locked, timeout;

  always #5 clk = ~clk;

  clk_period_meter #(.WIDTH(W), .TIMEOUT(32'(TO))) dut (
    .clk        (clk),
    .rst        (rst),
    .in_clk     (in_clk),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  int n_pass = 0;
  int n_total = 0;
  int mv_cnt = 0;
  int to_cnt = 0;
  bit lock_seen = 1'b0;
  bit started = 1'b0;

  // Reference model: edges are tracked as absolute clk-edge timestamps.
  int cyc = 0;
  bit h0 = 0, h1 = 0, h2 = 0;
  int mode = 0;            // 0 idle, 1 armed, 2 locked
  int t_rise = 0;
  int m_period = 0, m_high = 0, m_hilat = 0;
  bit m_mv = 0, m_lock = 0, m_to = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  always @(posedge clk) begin
    bit lvl_rise, lvl_fall;
    cyc++;
    started = 1'b1;
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0;
      mode = 0; t_rise = cyc;
      m_period = 0; m_high = 0; m_hilat = 0;
      m_mv = 0; m_lock = 0; m_to = 0;
    end else begin
      // The level seen by the meter lags in_clk by two sampling edges.
      lvl_rise = h1 && !h2;
      lvl_fall = !h1 && h2;
      m_mv = 0;
      m_to = 0;
      if (mode == 0) begin
        if (lvl_rise) begin
          mode = 1;
          t_rise = cyc;
        end
      end else if (lvl_rise) begin
        m_period = cyc - t_rise;
        m_high   = m_hilat;
        m_mv     = 1;
        mode     = 2;
        t_rise   = cyc;
      end else begin
        if (lvl_fall) m_hilat = cyc - t_rise;
        if (cyc - t_rise == TO) begin
          mode = 0;
          m_to = 1;
        end
      end
      m_lock = (mode == 2);
      h2 = h1; h1 = h0; h0 = in_clk;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("period", period, m_period);
      check("high_time", high_time, m_high);
      check("meas_valid", meas_valid, m_mv);
      check("locked", locked, m_lock);
      check("timeout", timeout, m_to);
      if (meas_valid) mv_cnt++;
      if (timeout) to_cnt++;
      if (locked) lock_seen = 1'b1;
    end
  end

  task automatic wave(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        in_clk = (i < hi);
      end
  endtask

  task automatic hold(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_clk = lvl;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int mv0, to0;
    rst = 1'b1;
    in_clk = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_locked", locked, 0);
    check("rst_mv", meas_valid, 0);
    rst = 1'b0;

    // Divider-style input: first measurement on the second rise.
    mv0 = mv_cnt;
    wave(500, 250, 4);
    settle();
    check("A_mv_count", mv_cnt - mv0, 3);
    check("A_period", period, 500);
    check("A_high", high_time, 250);
    check("A_locked", locked, 1);

    // Input stops: one timeout, measurements retained.
    to0 = to_cnt;
    hold(1'b0, 1100);
    settle();
    check("B_to_count", to_cnt - to0, 1);
    check("B_locked", locked, 0);
    check("B_period", period, 500);
    check("B_high", high_time, 250);

    // Reset mid-measurement while locked.
    wave(500, 250, 3);
    hold(1'b1, 100);
    @(negedge clk);
    rst = 1'b1;
    in_clk = 1'b0;
    @(negedge clk);
    #1;
    check("C_rst_period", period, 0);
    check("C_rst_high", high_time, 0);
    check("C_rst_locked", locked, 0);
    check("C_rst_to", timeout, 0);
    rst = 1'b0;
    mv0 = mv_cnt;
    hold(1'b0, 400);
    wave(500, 250, 2);
    settle();
    check("C_mv_count", mv_cnt - mv0, 1);
    check("C_period", period, 500);
    check("C_locked", locked, 1);

    // Fastest supported input.
    mv0 = mv_cnt;
    wave(4, 2, 10);
    settle();
    check("D_mv_count", mv_cnt - mv0, 10);
    check("D_period", period, 4);
    check("D_high", high_time, 2);

    // Period exactly TIMEOUT: rise wins.
    to0 = to_cnt;
    wave(1000, 500, 3);
    settle();
    check("E_period", period, 1000);
    check("E_high", high_time, 500);
    check("E_to_count", to_cnt - to0, 0);
    check("E_locked", locked, 1);

    // Period just over TIMEOUT: never measures, times out each time.
    to0 = to_cnt;
    mv0 = mv_cnt;
    wave(1001, 500, 2);
    hold(1'b0, 1200);
    settle();
    check("F_to_count", to_cnt - to0, 3);
    check("F_mv_count", mv_cnt - mv0, 0);
    check("F_period", period, 1000);
    check("F_locked", locked, 0);

    // Single rise then low forever.
    to0 = to_cnt;
    mv0 = mv_cnt;
    lock_seen = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 1200);
    settle();
    check("G_mv_count", mv_cnt - mv0, 0);
    check("G_to_count", to_cnt - to0, 1);
    check("G_lock_seen", lock_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of all measurement counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 32'd100000, max clk cycles without an in_clk rising edge before lock is lost (2 <= TIMEOUT <= 2^WIDTH-1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_clk  input  1  slow/divided clock under measurement, asynchronous to clk.
REQ-006 SHALL have port period  output  WIDTH  last measured rising-to-rising interval, in clk cycles.
REQ-007 SHALL have port high_time  output  WIDTH  last measured rising-to-falling interval, in clk cycles.
REQ-008 SHALL have port meas_valid  output  1  one-cycle pulse: period/high_time just updated.
REQ-009 SHALL have port locked  output  1  high while consecutive rising edges arrive within TIMEOUT.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on loss of lock.

Function
REQ-011 SHALL sample in_clk through a 2-flop synchronizer (s1, s2) plus history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 SHALL implement FSM states IDLE, ARM, LOCKED; all outputs registered.
REQ-013 IDLE: counters held; on rise -> ARM, per_cnt <= 1, hi_cnt <= 1.
REQ-014 ARM: on rise -> LOCKED, latch period/high_time, pulse meas_valid (first valid measurement = second rise after IDLE).
REQ-015 LOCKED: on each rise, period <= per_cnt, high_time <= hi_latched, meas_valid <= 1, per_cnt <= 1, hi_cnt <= 1.
REQ-016 In ARM/LOCKED, per_cnt SHALL increment by 1 each cycle without rise; hi_cnt SHALL increment while s2 = 1 and no fall; on fall, hi_latched <= hi_cnt.
REQ-017 A 500-cycle in_clk period with 250 high cycles SHALL yield period = 500, high_time = 250.
REQ-018 Timeout: in ARM or LOCKED, if per_cnt == TIMEOUT and no rise that cycle -> IDLE, timeout pulse for 1 cycle, locked <= 0.
REQ-019 Rise and per_cnt == TIMEOUT in the same cycle: rise wins, measurement taken (period = TIMEOUT), no timeout.
REQ-020 per_cnt SHALL never exceed TIMEOUT; no wrap-around possible.
REQ-021 period and high_time SHALL hold last values through timeout and IDLE until the next meas_valid.
REQ-022 locked SHALL be 1 exactly when state == LOCKED.
REQ-023 Latency: if edge k first samples in_clk = 1 (s1 = 1), meas_valid/period update SHALL be visible after edge k+2.
REQ-024 Minimum supported in_clk: high and low phases each >= 2 clk cycles; faster input gives unspecified values but no hang (timeout path still works).

Reset
REQ-025 rst high at a clk edge SHALL clear s1, s2, s3, per_cnt, hi_cnt, hi_latched, period, high_time, meas_valid, locked, timeout to 0 and set state IDLE.
REQ-026 Reset mid-measurement SHALL discard partial counts; after release, two rises are needed before the next meas_valid.
REQ-027 rst SHALL take priority over rise, fall and timeout in the same cycle.

Verification
REQ-028 Divider-style in_clk (period 500, high 250), TIMEOUT default -> first meas_valid at second rise, period = 500, high_time = 250, locked = 1; repeats every 500 cycles.
REQ-029 After lock, hold in_clk low, TIMEOUT = 2000 -> exactly one timeout pulse 2000 cycles after last rise, locked = 0, period stays 500.
REQ-030 rst pulsed 100 cycles after a rise while LOCKED -> all outputs 0 next cycle; first meas_valid only at second rise after release.
REQ-031 in_clk period 4 (high 2) -> every rise gives period = 4, high_time = 2, meas_valid every 4 cycles.
REQ-032 TIMEOUT = 1000, in_clk period exactly 1000 -> meas_valid with period = 1000, timeout never asserted, locked stays 1.
REQ-033 Single rise then in_clk low forever -> state ARM, no meas_valid, timeout pulse after TIMEOUT cycles, locked never 1.
